// File: rtl/seq_alu_mdu.sv
// seq_alu_mdu: multi-cycle EX ALU with iterative mul/div over valid/ready handshakes
// Optional flush port enabled by defining ALU_MDU_FLUSH_EN.
module seq_alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
`ifdef ALU_MDU_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] S_hi,
  output logic             overflow
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CW = SHAMT_W + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic fl, accept, mdu_in, sgn_in, last, is_mul, sa, sb, neg, dz, alu_ovf;
  logic [3:0] op;
  logic [CW-1:0] cnt;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0] a_q, mcand, hi, lo, hi_n, lo_n, alu_s, sum, dif, fin_s, fin_hi;
  logic [WIDTH:0] mul_sum, div_rem, div_dif;
  logic [2*WIDTH-1:0] prod_neg;
`ifdef ALU_MDU_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_ready && in_valid;
  assign mdu_in    = ctrl >= 4'b1011 && ctrl != 4'b1111;
  assign sgn_in    = ctrl == 4'b1011 || ctrl == 4'b1101;
  assign last      = cnt == CW'(1);
  assign is_mul    = op == 4'b1011 || op == 4'b1100;
  assign shamt     = B[SHAMT_W-1:0];
  assign sum       = A + B;
  assign dif       = A - B;
  always_comb begin
    alu_s   = '0;
    alu_ovf = 1'b0;
    case (ctrl)
      4'b0000: begin alu_s = sum; alu_ovf = A[WIDTH-1] == B[WIDTH-1] && sum[WIDTH-1] != A[WIDTH-1]; end
      4'b0001: begin alu_s = dif; alu_ovf = A[WIDTH-1] != B[WIDTH-1] && dif[WIDTH-1] != A[WIDTH-1]; end
      4'b0010: alu_s = A & B;
      4'b0011: alu_s = A | B;
      4'b0100: alu_s = ~(A | B);
      4'b0101: alu_s = A ^ B;
      4'b0110: alu_s = A << shamt;
      4'b0111: alu_s = $signed(A) >>> shamt;
      4'b1000: alu_s = A >> shamt;
      4'b1001: alu_s = {{(WIDTH-1){1'b0}}, A < B};
      4'b1010: alu_s = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      default: alu_s = '0;
    endcase
  end
  // {hi,lo} is the shift-add product register or the restoring remainder/quotient pair
  assign mul_sum  = {1'b0, hi} + {1'b0, mcand & {WIDTH{lo[0]}}};
  assign div_rem  = {hi, lo[WIDTH-1]};
  assign div_dif  = div_rem - {1'b0, mcand};
  assign hi_n     = is_mul ? mul_sum[WIDTH:1] : (div_dif[WIDTH] ? div_rem[WIDTH-1:0] : div_dif[WIDTH-1:0]);
  assign lo_n     = is_mul ? {mul_sum[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], ~div_dif[WIDTH]};
  assign prod_neg = -{hi_n, lo_n};
  assign neg      = sa ^ sb;
  assign dz       = mcand == '0;
  assign fin_s    = is_mul ? (neg ? prod_neg[WIDTH-1:0] : lo_n) : dz ? '1 : neg ? -lo_n : lo_n;
  assign fin_hi   = is_mul ? (neg ? prod_neg[2*WIDTH-1:WIDTH] : hi_n) : dz ? a_q : sa ? -hi_n : hi_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = mdu_in ? BUSY : DONE;
      BUSY:    if (last) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (fl) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op <= '0; a_q <= '0; mcand <= '0; hi <= '0; lo <= '0; sa <= 1'b0; sb <= 1'b0;
      cnt <= '0; S <= '0; S_hi <= '0; overflow <= 1'b0;
    end else if (fl) begin
      cnt <= '0;
    end else if (accept) begin
      op    <= ctrl;
      a_q   <= A;
      sa    <= sgn_in & A[WIDTH-1];
      sb    <= sgn_in & B[WIDTH-1];
      mcand <= (sgn_in & B[WIDTH-1]) ? -B : B;
      lo    <= (sgn_in & A[WIDTH-1]) ? -A : A;
      hi    <= '0;
      cnt   <= mdu_in ? CW'(WIDTH) : '0;
      if (!mdu_in) begin
        S        <= alu_s;
        S_hi     <= '0;
        overflow <= alu_ovf;
      end
    end else if (state == BUSY) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - CW'(1);
      if (last) begin
        S        <= fin_s;
        S_hi     <= fin_hi;
        overflow <= 1'b0;
      end
    end
endmodule

// File: tb/tb_seq_alu_mdu.sv
// tb_seq_alu_mdu: directed edge cases plus random ops against an arithmetic reference model
module tb_seq_alu_mdu;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [3:0] ctrl = '0;
  logic in_ready, out_valid, overflow;
  logic [31:0] S, S_hi;
  int n_cmp = 0, n_bad = 0;
`ifdef ALU_MDU_FLUSH_EN
  logic flush = 1'b0;
`endif
  seq_alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
`ifdef ALU_MDU_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .ctrl(ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .S_hi(S_hi), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] s, output logic [31:0] h, output logic o);
    longint r;
    longint unsigned u;
    int sa, sb;
    sa = a; sb = b; s = '0; h = '0; o = 1'b0;
    case (c)
      4'd0: begin r = longint'(sa) + longint'(sb); s = r[31:0]; o = r != longint'(int'(r)); end
      4'd1: begin r = longint'(sa) - longint'(sb); s = r[31:0]; o = r != longint'(int'(r)); end
      4'd2: s = a & b;
      4'd3: s = a | b;
      4'd4: s = ~(a | b);
      4'd5: s = a ^ b;
      4'd6: s = a << b[4:0];
      4'd7: s = sa >>> b[4:0];
      4'd8: s = a >> b[4:0];
      4'd9: s = {31'b0, a < b};
      4'd10: s = {31'b0, sa < sb};
      4'd11: begin r = longint'(sa) * longint'(sb); {h, s} = r; end
      4'd12: begin u = {32'b0, a} * {32'b0, b}; {h, s} = u; end
      4'd13: begin
        if (b == 0) begin s = '1; h = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin s = a; h = '0; end
        else begin s = sa / sb; h = sa % sb; end
      end
      4'd14: begin
        if (b == 0) begin s = '1; h = a; end
        else begin s = a / b; h = a % b; end
      end
      default: ;
    endcase
  endfunction
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] es, eh;
    logic eo;
    int lat, want;
    model(c, a, b, es, eh, eo);
    want = (c >= 4'd11 && c <= 4'd14) ? 33 : 1;
    @(negedge clk);
    chk("in_ready_before", in_ready, 1'b1);
    in_valid = 1'b1; ctrl = c; A = a; B = b;
    @(negedge clk);
    in_valid = 1'b0; A = $urandom; B = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      chk("in_ready_busy", in_ready, 1'b0);
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency op%0d", c), lat, want);
    chk($sformatf("S op%0d a=%h b=%h", c, a, b), S, es);
    chk($sformatf("S_hi op%0d a=%h b=%h", c, a, b), S_hi, eh);
    chk($sformatf("ovf op%0d", c), overflow, eo);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_take", out_valid, 1'b0);
  endtask
  function automatic logic [31:0] pick();
    logic [31:0] sp [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    return ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : 32'($urandom);
  endfunction
  initial begin
    logic [31:0] held;
    #2;
    chk("rst in_ready", in_ready, 1'b1);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst S", S, 32'h0);
    chk("rst S_hi", S_hi, 32'h0);
    chk("rst ovf", overflow, 1'b0);
    @(negedge clk); reset = 1'b0;
    run_op(4'd0, 32'h7FFF_FFFF, 32'h1);
    run_op(4'd7, 32'h8000_0000, 32'h24);
    run_op(4'd8, 32'h8000_0000, 32'h24);
    run_op(4'd11, 32'hFFFF_FFFE, 32'h3);
    run_op(4'd12, 32'hFFFF_FFFE, 32'h3);
    run_op(4'd13, 32'hFFFF_FFF9, 32'h2);
    run_op(4'd14, 32'h5, 32'h0);
    run_op(4'd13, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(4'd13, 32'hFFFF_FFF9, 32'h0);
    run_op(4'd1, 32'h8000_0000, 32'h1);
    run_op(4'd15, 32'h1234, 32'h5678);
    // backpressure: result held, new ops ignored, no accept on the take cycle
    @(negedge clk);
    in_valid = 1'b1; ctrl = 4'd0; A = 32'd10; B = 32'd20;
    @(negedge clk);
    ctrl = 4'd5; A = 32'hFFFF; B = 32'h1;
    for (int i = 0; i < 5; i++) begin
      chk("bp S", S, 32'd30);
      chk("bp in_ready", in_ready, 1'b0);
      chk("bp out_valid", out_valid, 1'b1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp take out_valid", out_valid, 1'b0);
    chk("bp take in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    // async reset mid-division
    @(negedge clk);
    in_valid = 1'b1; ctrl = 4'd13; A = 32'd100; B = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    held = S;
    reset = 1'b1;
    #1;
    chk("arst in_ready", in_ready, 1'b1);
    chk("arst out_valid", out_valid, 1'b0);
    chk("arst S", S, 32'h0);
    @(negedge clk); reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("arst no result", out_valid, 1'b0);
`ifdef ALU_MDU_FLUSH_EN
    run_op(4'd2, 32'hF0F0, 32'hFF00);
    held = S;
    @(negedge clk);
    in_valid = 1'b1; ctrl = 4'd14; A = 32'd50; B = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush in_ready", in_ready, 1'b1);
    chk("flush S kept", S, held);
    repeat (40) @(negedge clk);
    chk("flush no result", out_valid, 1'b0);
`endif
    for (int i = 0; i < 80; i++) run_op(4'($urandom_range(0, 15)), pick(), pick());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
